// File: rtl/hazard_pkg.sv
// Shared types and default constants for the pipeline hazard controller.
// The sat_inc helper backs the optional HAZARD_PERF_CNT_EN event counters.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

    localparam int DEF_NUM_RD_PORTS = 2;
    localparam int DEF_ADDR_W       = 4;
    localparam int DEF_MC_LAT       = 4;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forward-source select for one execute-stage read port (M beats W).
// The all-ones address is the PC and always reads the register file path.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] wa_m,
    input  logic [ADDR_W-1:0] wa_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output fwd_sel_t          sel
);

    always_comb begin
        sel = FWD_RF;
        if (ra != '1) begin
            if (reg_write_m && (ra == wa_m)) begin
                sel = FWD_M;
            end else if (reg_write_w && (ra == wa_w)) begin
                sel = FWD_W;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: forwarding, load-use stall, branch flush, multicycle-op FSM.
// Define HAZARD_PERF_CNT_EN to add the saturating stall/flush event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_RD_PORTS = DEF_NUM_RD_PORTS,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int MC_LAT       = DEF_MC_LAT
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           regWriteM,
    input  logic                           regWriteW,
    input  logic [ADDR_W-1:0]              WA3M,
    input  logic [ADDR_W-1:0]              WA3W,
    input  logic [ADDR_W-1:0]              WA3E,
    input  logic [NUM_RD_PORTS*ADDR_W-1:0] RAE,
    input  logic [NUM_RD_PORTS*ADDR_W-1:0] RAD,
    input  logic                           memtoRegE,
    input  logic                           branchTakenE,
    input  logic                           mc_startE,
    output logic [NUM_RD_PORTS*2-1:0]      forwardE,
    output logic                           stallF,
    output logic                           stallD,
    output logic                           stallE,
    output logic                           flushD,
    output logic                           flushE,
    output logic                           flushM,
    output logic                           mc_busy,
`ifdef HAZARD_PERF_CNT_EN
    input  logic                           cnt_clr,
    output logic [31:0]                    stall_cnt,
    output logic [31:0]                    flush_cnt,
`endif
    output logic                           mc_done
);

    localparam int CNT_W = $clog2(MC_LAT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MC_LAT - 1);

    fwd_sel_t sel [NUM_RD_PORTS];

    for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_port
        fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_sel (
            .ra          (RAE[i*ADDR_W +: ADDR_W]),
            .wa_m        (WA3M),
            .wa_w        (WA3W),
            .reg_write_m (regWriteM),
            .reg_write_w (regWriteW),
            .sel         (sel[i])
        );
        assign forwardE[2*i +: 2] = sel[i];
    end

    logic ldstall;

    always_comb begin
        ldstall = 1'b0;
        for (int i = 0; i < NUM_RD_PORTS; i++) begin
            if (RAD[i*ADDR_W +: ADDR_W] == WA3E) ldstall = 1'b1;
        end
        ldstall = ldstall & memtoRegE;
    end

    mc_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_cyc, can_start, mc_accept, mcstall;

    // cnt_q numbers the BUSY cycles 1..MC_LAT-1; the final one may also accept a new op.
    assign last_cyc  = (state_q == MC_BUSY) && (cnt_q == LAST_CNT);
    assign can_start = (state_q == MC_IDLE) || last_cyc;
    assign mc_accept = reset_n && mc_startE && can_start;
    assign mcstall   = reset_n && (((state_q == MC_BUSY) && !last_cyc) || mc_accept);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (mc_accept) begin
            state_d = MC_BUSY;
            cnt_d   = CNT_W'(1);
        end else if (last_cyc) begin
            state_d = MC_IDLE;
            cnt_d   = '0;
        end else if (state_q == MC_BUSY) begin
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mc_busy = reset_n && (state_q == MC_BUSY);
    assign mc_done = reset_n && last_cyc;

    assign stallF = ldstall | mcstall;
    assign stallD = ldstall | mcstall;
    assign stallE = mcstall;
    assign flushD = branchTakenE;
    assign flushE = (ldstall | branchTakenE) & ~mcstall;
    assign flushM = mcstall;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = sat_inc(stall_cnt_q, stallF);
        flush_cnt_d = sat_inc(flush_cnt_q, flushD | flushE);
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic
// against a cycle-numbered reference model of the multicycle window.
module tb_hazard_ctrl;

    localparam int NP     = 2;
    localparam int AW     = 4;
    localparam int MC_LAT = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          regWriteM, regWriteW;
    logic [AW-1:0] WA3M, WA3W, WA3E;
    logic [NP*AW-1:0] RAE, RAD;
    logic          memtoRegE, branchTakenE, mc_startE;
    logic [NP*2-1:0] forwardE;
    logic          stallF, stallD, stallE, flushD, flushE, flushM;
    logic          mc_busy, mc_done;
`ifdef HAZARD_PERF_CNT_EN
    logic          cnt_clr;
    logic [31:0]   stall_cnt, flush_cnt;
`endif

    hazard_ctrl #(.NUM_RD_PORTS(NP), .ADDR_W(AW), .MC_LAT(MC_LAT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .regWriteM    (regWriteM),
        .regWriteW    (regWriteW),
        .WA3M         (WA3M),
        .WA3W         (WA3W),
        .WA3E         (WA3E),
        .RAE          (RAE),
        .RAD          (RAD),
        .memtoRegE    (memtoRegE),
        .branchTakenE (branchTakenE),
        .mc_startE    (mc_startE),
        .forwardE     (forwardE),
        .stallF       (stallF),
        .stallD       (stallD),
        .stallE       (stallE),
        .flushD       (flushD),
        .flushE       (flushE),
        .flushM       (flushM),
        .mc_busy      (mc_busy),
`ifdef HAZARD_PERF_CNT_EN
        .cnt_clr      (cnt_clr),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
`endif
        .mc_done      (mc_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model state: cycle number and start cycle of the current op
    int cyc = 0;
    int op_start = 0;
    bit op_active = 1'b0;
    int exp_stall_cnt = 0;
    int exp_flush_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [AW-1:0] ra);
        if (ra == 4'hF) return 2'b00;
        if (regWriteM && ra == WA3M) return 2'b10;
        if (regWriteW && ra == WA3W) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle_inputs();
        regWriteM = 0; regWriteW = 0;
        WA3M = 4'h1; WA3W = 4'h2; WA3E = 4'h3;
        RAE = 8'h00; RAD = 8'h00;
        memtoRegE = 0; branchTakenE = 0; mc_startE = 0;
`ifdef HAZARD_PERF_CNT_EN
        cnt_clr = 0;
`endif
    endtask

    // Check every output against the model for the current inputs, then advance one clock.
    task automatic cycle();
        logic eld, emc, last, nw, est, efl;
        @(negedge clk);
        eld  = memtoRegE && (RAD[3:0] == WA3E || RAD[7:4] == WA3E);
        last = op_active && (cyc == op_start + MC_LAT - 1);
        nw   = reset_n && mc_startE && (!op_active || last);
        emc  = reset_n && ((op_active && !last) || nw);
        est  = eld || emc;
        efl  = branchTakenE || ((eld || branchTakenE) && !emc);
        chk("forwardE", forwardE, {fwd_ref(RAE[7:4]), fwd_ref(RAE[3:0])});
        chk("stallF", stallF, est);
        chk("stallD", stallD, est);
        chk("stallE", stallE, emc);
        chk("flushD", flushD, branchTakenE);
        chk("flushE", flushE, (eld || branchTakenE) && !emc);
        chk("flushM", flushM, emc);
        chk("mc_busy", mc_busy, reset_n && op_active);
        chk("mc_done", mc_done, reset_n && last);
`ifdef HAZARD_PERF_CNT_EN
        if (cyc > 0) begin
            chk("stall_cnt", stall_cnt, exp_stall_cnt);
            chk("flush_cnt", flush_cnt, exp_flush_cnt);
        end
        if (!reset_n || cnt_clr) begin
            exp_stall_cnt = 0;
            exp_flush_cnt = 0;
        end else begin
            exp_stall_cnt += int'(est);
            exp_flush_cnt += int'(efl);
        end
`else
        efl = efl; // flush total only tracked with counters built in
`endif
        if (!reset_n) begin
            op_active = 1'b0;
        end else if (nw) begin
            op_active = 1'b1;
            op_start  = cyc;
        end else if (last) begin
            op_active = 1'b0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] pick_addr();
        int r = $urandom_range(0, 4);
        return (r == 4) ? 4'hF : AW'(r);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset_n = 0;
        #1;
        repeat (2) cycle();
        reset_n = 1;
        cycle();

        // forwarding priority: M over W, then W alone
        RAE = 8'h03; WA3M = 4'h3; WA3W = 4'h3; regWriteM = 1; regWriteW = 1;
        #1 chk("fwd_m_prio", forwardE[1:0], 2'b10);
        cycle();
        regWriteM = 0;
        #1 chk("fwd_w", forwardE[1:0], 2'b01);
        cycle();

        // PC address never forwarded
        idle_inputs();
        RAE = 8'hF0; WA3M = 4'hF; regWriteM = 1;
        #1 chk("fwd_pc", forwardE[3:2], 2'b00);
        cycle();

        // load-use stall on port 1
        idle_inputs();
        memtoRegE = 1; WA3E = 4'h5; RAD = 8'h50;
        #1 chk("ld_stallF", stallF, 1'b1);
        chk("ld_stallD", stallD, 1'b1);
        chk("ld_flushE", flushE, 1'b1);
        cycle();
        RAD = 8'h60;
        #1 chk("nold_ctrl", {stallF, stallD, flushE}, 3'b000);
        cycle();

        // multicycle window with a load-use hazard inside it
        idle_inputs();
        mc_startE = 1;
        #1 chk("mc_t0_stallE", stallE, 1'b1);
        cycle();
        mc_startE = 0; memtoRegE = 1; WA3E = 4'h5; RAD = 8'h05;
        #1 chk("mc_t1_flushE", flushE, 1'b0);
        chk("mc_t1_stallE", stallE, 1'b1);
        cycle();
        idle_inputs();
        #1 chk("mc_t2_stallE", stallE, 1'b1);
        chk("mc_t2_done", mc_done, 1'b0);
        cycle();
        #1 chk("mc_t3_stallE", stallE, 1'b0);
        chk("mc_t3_done", mc_done, 1'b1);
        cycle();
        #1 chk("mc_t4_done", mc_done, 1'b0);
        cycle();

        // reset aborts an op; next start is clean
        mc_startE = 1;
        cycle();
        mc_startE = 0; reset_n = 0;
        cycle();
        reset_n = 1;
        #1 chk("rst_busy", mc_busy, 1'b0);
        chk("rst_stallE", stallE, 1'b0);
        cycle();
        mc_startE = 1;
        #1 chk("rst_restart", stallE, 1'b1);
        cycle();
        mc_startE = 0;
        repeat (2) cycle();
        // back-to-back start on the final cycle
        mc_startE = 1;
        #1 chk("b2b_done", mc_done, 1'b1);
        cycle();
        mc_startE = 0;
        #1 chk("b2b_stallE", stallE, 1'b1);
        repeat (4) cycle();

`ifdef HAZARD_PERF_CNT_EN
        idle_inputs();
        cnt_clr = 1;
        cycle();
        cnt_clr = 0;
        memtoRegE = 1; WA3E = 4'h5; RAD = 8'h50;
        repeat (5) cycle();
        idle_inputs();
        branchTakenE = 1;
        repeat (2) cycle();
        idle_inputs();
        #1 chk("perf_stall", stall_cnt, 32'd5);
        chk("perf_flush", flush_cnt, 32'd7);
        cnt_clr = 1;
        cycle();
        cnt_clr = 0;
        #1 chk("perf_clr", {stall_cnt, flush_cnt}, 0);
        cycle();
`endif

        for (int n = 0; n < 600; n++) begin
            reset_n   = ($urandom_range(0, 40) != 0);
            regWriteM = 1'($urandom_range(0, 1));
            regWriteW = 1'($urandom_range(0, 1));
            WA3M = pick_addr(); WA3W = pick_addr(); WA3E = pick_addr();
            RAE  = {pick_addr(), pick_addr()};
            RAD  = {pick_addr(), pick_addr()};
            memtoRegE    = ($urandom_range(0, 2) == 0);
            mc_startE    = ($urandom_range(0, 4) == 0);
            branchTakenE = !mc_startE && ($urandom_range(0, 4) == 0);
`ifdef HAZARD_PERF_CNT_EN
            cnt_clr = ($urandom_range(0, 30) == 0);
`endif
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter NUM_RD_PORTS, default 2, number of execute-stage register read ports (legal 1..4).
REQ-002 Parameter ADDR_W, default 4, register address width.
REQ-003 Parameter MC_LAT, default 4, cycles a multicycle op occupies E (legal 2..16).
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 regWriteM, regWriteW  in  1 each  M/W stage register-write enables.
REQ-007 WA3M, WA3W, WA3E  in  ADDR_W each  M/W/E destination addresses.
REQ-008 RAE  in  NUM_RD_PORTS*ADDR_W  E-stage source addresses; port i at bits [i*ADDR_W +: ADDR_W].
REQ-009 RAD  in  NUM_RD_PORTS*ADDR_W  D-stage source addresses, same packing.
REQ-010 memtoRegE, branchTakenE, mc_startE  in  1 each  load in E, taken branch in E, multicycle op entering E.
REQ-011 forwardE  out  NUM_RD_PORTS*2  per-port forward select; port i at [2*i +: 2].
REQ-012 stallF, stallD, stallE, flushD, flushE, flushM  out  1 each  pipeline control.
REQ-013 mc_busy, mc_done  out  1 each  multicycle FSM busy, final-cycle pulse.

Function
REQ-014 Per port i, forwardE = 2'b10 if RAE[i]==WA3M & regWriteM; else 2'b01 if RAE[i]==WA3W & regWriteW; else 2'b00; M has priority.
REQ-015 Address all-ones (PC) SHALL never be forwarded: forwardE=2'b00 for that port.
REQ-016 Forwarding SHALL be combinational, zero latency, and valid in every cycle including stalls.
REQ-017 ldstall = memtoRegE & (any port RAD[i]==WA3E); ldstall SHALL assert stallF, stallD, flushE in the same cycle.
REQ-018 branchTakenE SHALL assert flushD and flushE in the same cycle.
REQ-019 FSM states IDLE, BUSY; IDLE->BUSY on mc_startE; BUSY->IDLE after final cycle; mc_startE ignored in BUSY.
REQ-020 From mc_startE in cycle t (IDLE), mcstall SHALL assert in cycles t..t+MC_LAT-2 exactly (MC_LAT-1 cycles).
REQ-021 mcstall SHALL assert stallF, stallD, stallE, flushM; mc_done SHALL pulse one cycle at t+MC_LAT-1 with mcstall low.
REQ-022 mc_busy SHALL equal (state==BUSY).
REQ-023 Priority: flushE SHALL be forced 0 whenever mcstall is 1; mc_startE with branchTakenE same cycle is illegal.
REQ-024 Back-to-back: mc_startE in cycle t+MC_LAT-1 (FSM returning IDLE) SHALL start a new op with no gap cycle.

Reset
REQ-025 reset_n low at a clk edge SHALL force state IDLE and clear the counter, aborting any op in progress.
REQ-026 During and after reset: mc_busy=0, mc_done=0, mcstall=0; other outputs follow inputs combinationally.

Configuration
REQ-027 Macro HAZARD_PERF_CNT_EN defined: add ports cnt_clr in 1, stall_cnt out 32, flush_cnt out 32.
REQ-028 stall_cnt counts cycles with stallF=1, flush_cnt cycles with flushD|flushE=1; both saturate at 32'hFFFFFFFF.
REQ-029 cnt_clr or reset SHALL zero both counters next edge; cnt_clr wins over increment.
REQ-030 Macro undefined: counter ports and logic SHALL be absent; all other behaviour identical.

Structure
REQ-031 Package hazard_pkg SHALL hold fwd_sel_t (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10), mc_state_t, and default parameter constants.
REQ-032 Sub-module fwd_sel (one port's REQ-014/015 logic) SHALL be instantiated NUM_RD_PORTS times by generate.

Verification
REQ-033 RAE[0]=3, WA3M=3, regWriteM=1, WA3W=3, regWriteW=1 -> forwardE[1:0]=2'b10; regWriteM=0 -> 2'b01.
REQ-034 RAE[1]=4'hF, WA3M=4'hF, regWriteM=1 -> forwardE[3:2]=2'b00.
REQ-035 memtoRegE=1, WA3E=5, RAD[1]=5 -> stallF=stallD=flushE=1 same cycle; RAD[1]=6 -> all 0.
REQ-036 MC_LAT=4, mc_startE at t -> stallE=1 at t,t+1,t+2; mc_done=1 only at t+3; ldstall during window -> flushE=0.
REQ-037 reset_n low at t+1 of a MC_LAT=4 op -> mc_busy=0, stalls 0 from t+2; mc_startE at t+3 starts cleanly.
REQ-038 HAZARD_PERF_CNT_EN: 5 ldstall cycles + 2 branchTakenE cycles -> stall_cnt=5, flush_cnt=7; cnt_clr -> both 0.
